// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetcher: FSM encoding,
// memory latency and default parameter values.
package if_pkg;

    localparam int MEM_LAT        = 2;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_INST_BYTES = 4;
    localparam int DEF_QDEPTH     = 4;
    localparam int DEF_REQ_GAP    = 9;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_inst_fifo.sv
// First-word-fall-through instruction queue with flush and occupancy count.
// The head word reads as zero while the queue is empty.
module if_inst_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != FULL);
    assign do_pop  = pop_i && (cnt_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; occupancy gating below keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch.sv
// Byte-serial instruction prefetcher: fetches one instruction at a time from
// mem_ctrl, assembles it little-endian and queues it for the decode stage.
module if_prefetch
    import if_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INST_BYTES = DEF_INST_BYTES,
    parameter int QDEPTH     = DEF_QDEPTH,
    parameter int REQ_GAP    = DEF_REQ_GAP
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    if_request,
    output logic [ADDR_W-1:0]       if_addr,
    input  logic                    mem_gnt,
    input  logic [7:0]              mem_ctrl_data,
    input  logic                    branch_enable_i,
    input  logic [ADDR_W-1:0]       branch_addr_i,
    output logic                    inst_valid_o,
    output logic [8*INST_BYTES-1:0] inst_o,
    output logic [ADDR_W-1:0]       pc_o,
    input  logic                    id_ready_i
);
    localparam int IW = 8 * INST_BYTES;
    localparam int KW = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
    localparam int GW = (REQ_GAP > 0) ? $clog2(REQ_GAP + 1) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [KW-1:0] K_LAST   = KW'(INST_BYTES - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(REQ_GAP);
    localparam logic [CW-1:0] Q_FULL   = CW'(QDEPTH);
    localparam logic [CW-1:0] Q_ALMOST = CW'(QDEPTH - 1);

    if_state_e          state_q, state_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [KW-1:0]      k_q, k_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [IW-1:0]      asm_q, asm_d;
    logic [MEM_LAT-1:0] sv_q;
    logic [KW-1:0]      sidx_q [MEM_LAT];

    logic               gnt_acc, arrive, push, pop;
    logic [KW-1:0]      arr_idx;
    logic [CW-1:0]      q_count;
    logic [ADDR_W+IW-1:0] q_rdata;

    assign gnt_acc = (state_q == ST_FETCH) && mem_gnt;
    assign arrive  = sv_q[MEM_LAT-1];
    assign arr_idx = sidx_q[MEM_LAT-1];
    assign push    = arrive && (arr_idx == K_LAST) && !branch_enable_i;
    assign pop     = inst_valid_o && id_ready_i;

    always_comb begin
        asm_d = asm_q;
        if (arrive) asm_d[8*arr_idx +: 8] = mem_ctrl_data;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        k_d        = k_q;
        fetch_pc_d = fetch_pc_q;
        if_request = 1'b0;
        if_addr    = '0;
        case (state_q)
            ST_GAP: begin
                if (gap_q != '0)          gap_d   = gap_q - GW'(1);
                else if (q_count < Q_FULL) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if_request = 1'b1;
                if_addr    = fetch_pc_q + ADDR_W'(k_q);
                if (mem_gnt) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (push) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
                    gap_d      = GAP_INIT;
                    // With no gap, refetch at once only if the push leaves a free slot.
                    if ((REQ_GAP == 0) && (pop || (q_count < Q_ALMOST))) state_d = ST_FETCH;
                    else                                                 state_d = ST_GAP;
                end
            end
            default: state_d = ST_GAP;
        endcase
        if (branch_enable_i) begin
            state_d    = (REQ_GAP == 0) ? ST_FETCH : ST_GAP;
            gap_d      = GAP_INIT;
            k_d        = '0;
            fetch_pc_d = branch_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_GAP;
            gap_q      <= GAP_INIT;
            k_q        <= '0;
            fetch_pc_q <= '0;
            asm_q      <= '0;
            sv_q       <= '0;
            for (int i = 0; i < MEM_LAT; i++) sidx_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            k_q        <= k_d;
            fetch_pc_q <= fetch_pc_d;
            asm_q      <= asm_d;
            sv_q       <= branch_enable_i ? '0 : {sv_q[MEM_LAT-2:0], gnt_acc};
            sidx_q[0]  <= k_q;
            for (int i = 1; i < MEM_LAT; i++) sidx_q[i] <= sidx_q[i-1];
        end
    end

    if_inst_fifo #(
        .W     (ADDR_W + IW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_enable_i),
        .push_i  (push),
        .wdata_i ({fetch_pc_q, asm_d}),
        .pop_i   (pop),
        .rdata_o (q_rdata),
        .count_o (q_count)
    );

    assign inst_valid_o = (q_count != '0);
    assign pc_o         = q_rdata[ADDR_W+IW-1 -: ADDR_W];
    assign inst_o       = q_rdata[IW-1:0];

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter ADDR_W, 32, address/PC width in bits.
REQ-002 Parameter INST_BYTES, 4, bytes per instruction (1..8); instruction width IW = 8*INST_BYTES.
REQ-003 Parameter QDEPTH, 4, instruction queue entries (power of 2, >=2).
REQ-004 Parameter REQ_GAP, 9, idle cycles between instruction fetches (0 allowed = back-to-back).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 if_request  output  1  byte read request to mem_ctrl.
REQ-008 if_addr  output  ADDR_W  byte address of current request.
REQ-009 mem_gnt  input  1  mem_ctrl accepts the request this cycle.
REQ-010 mem_ctrl_data  input  8  returned byte, valid exactly MEM_LAT=2 cycles after its granted request.
REQ-011 branch_enable_i  input  1  redirect/flush strobe from ID.
REQ-012 branch_addr_i  input  ADDR_W  redirect target.
REQ-013 inst_valid_o  output  1  queue head valid.
REQ-014 inst_o  output  IW  queue head instruction, little-endian byte assembly.
REQ-015 pc_o  output  ADDR_W  PC of queue head.
REQ-016 id_ready_i  input  1  ID consumes head when inst_valid_o && id_ready_i.

Function
REQ-017 FSM states: GAP, FETCH, DRAIN; GAP counts gap_cnt down from REQ_GAP to 0.
REQ-018 GAP -> FETCH when gap_cnt==0 and queue count < QDEPTH; otherwise stay (gap_cnt holds at 0 while queue full).
REQ-019 FETCH: if_request=1, if_addr = fetch_pc + k, k = byte index 0..INST_BYTES-1; k increments only on cycles with mem_gnt=1; mem_gnt=0 holds if_addr and k.
REQ-020 FETCH -> DRAIN on the edge granting byte INST_BYTES-1; if_request=0 in DRAIN and GAP.
REQ-021 A 2-stage valid/index shift register tracks granted bytes; byte sampled at edge t+2 for grant at edge t, stored at bits [8i+7:8i].
REQ-022 On arrival of byte INST_BYTES-1: push {fetch_pc, assembled inst} into queue, fetch_pc += INST_BYTES (wraps modulo 2^ADDR_W), state -> GAP with gap_cnt=REQ_GAP; if REQ_GAP==0 state -> FETCH directly when space permits.
REQ-023 Queue is first-word-fall-through; inst_valid_o = (count!=0); inst_o/pc_o read 0 when empty.
REQ-024 Push and pop in the same cycle: count unchanged, both take effect.
REQ-025 At most one instruction in flight; start gate (REQ-018) guarantees push never hits a full queue.
REQ-026 branch_enable_i=1 at an edge (any state): queue emptied, shift-register valids cleared (late bytes discarded), k=0, fetch_pc=branch_addr_i, state -> GAP with gap_cnt=REQ_GAP (FETCH if REQ_GAP==0); simultaneous pop and push ignored.
REQ-027 Fetch-to-ID latency with mem_gnt always 1: inst_valid_o rises INST_BYTES+2 cycles after FETCH entry.

Reset
REQ-028 rst low asynchronously forces: if_request=0, if_addr=0, fetch_pc=0, k=0, queue empty, inst_valid_o=0, inst_o=0, pc_o=0, shift valids=0, state GAP, gap_cnt=REQ_GAP.
REQ-029 Reset mid-fetch discards partial instruction; bytes returning after release are ignored.

Structure
REQ-030 Shared package if_pkg holds FSM state encoding, MEM_LAT=2 constant, default parameter values.
REQ-031 Queue implemented as sub-module if_inst_fifo (width ADDR_W+IW, depth QDEPTH, FWFT, count output).

Verification
REQ-032 Defaults, mem_gnt=1, id_ready=1, memory holds 0x00000013 at 0x0: after reset release + 9 gap cycles + 6, inst_valid_o=1, inst_o=0x00000013, pc_o=0x0; next at pc_o=0x4.
REQ-033 mem_gnt toggling 1,0,1,0...: if_addr held on gnt=0 cycles, assembled word still correct, bytes in order 0x0..0x3.
REQ-034 REQ_GAP=0, id_ready=0: exactly 4 instructions queued (pc 0x0,0x4,0x8,0xC), if_request stays 0; raise id_ready -> fetch resumes at 0x10.
REQ-035 branch_enable_i=1, branch_addr_i=0x100 while 2 bytes in flight: inst_valid_o=0 next cycle, stale bytes dropped, first new inst has pc_o=0x100.
REQ-036 rst asserted mid-FETCH then released: all outputs 0 immediately, first fetch again at 0x0 after REQ_GAP cycles.
REQ-037 ADDR_W=8, fetch_pc=0xFC: next fetch_pc wraps to 0x00.
